dq_tablo_yonetici: RTL and testbench
====================================

// Module: dq_tablo_yonetici
// PURPOSE
//  Owns the JPEG quantization tables and schedules which one the dequantizer uses.
//  - Loads DQT segment bytes from the header parser into 4 table banks.
//    Entries arrive in zigzag order and are stored in natural (row*8+col) order.
//  - Tracks the MCU component sequence (Y..Y, Cb, Cr) from end-of-block handshakes.
//  - Gives the dequantizer a same-cycle coefficient lookup from the active component's table.
// PARAMETERS
//  TABLO_SAYISI  4   number of table banks (Tq 0..3)
//  DQ_TABLO_BIT  8   entry width; 8-bit precision (Pq=0) only
//  BLOCK_AREA    64  entries per table
// PORTS
//  clk_i              in   1   clock
//  rstn_i             in   1   async active-low reset
//  dqt_veri_i         in   8   DQT payload byte (length field already stripped)
//  dqt_gecerli_i      in   1   payload byte valid
//  dqt_segment_son_i  in   1   qualifies the last byte of the segment
//  dqt_hazir_o        out  1   loader ready
//  dekod_aktif_i      in   1   entropy/dequant pipeline busy with a frame
//  yeni_cerceve_i     in   1   1-cycle pulse at start of scan
//  bilesen_sayisi_i   in   2   components in scan: 1 or 3
//  mcu_y_blok_i       in   3   Y blocks per MCU, 1..4
//  bilesen_tablo_i    in   6   {Cr,Cb,Y} Tq selectors, 2 bits each
//  blk_gecerli_i      in   1   dequantizer input valid (observed only)
//  blk_hazir_i        in   1   dequantizer input ready (observed only)
//  blk_son_i          in   1   last coefficient of block (observed only)
//  dq_index_i         in   6   natural-order index from dequantizer
//  dq_katsayi_o       out  8   table entry for dq_index_i
//  aktif_bilesen_o    out  2   0=Y 1=Cb 2=Cr
//  aktif_tablo_o      out  2   Tq in use
//  tablo_gecerli_o    out  4   per-bank loaded flag
//  dq_hata_o          out  1   sticky error: Pq!=0, Tq>3, truncated or overlong segment
// BEHAVIOUR
//  Reset values: all outputs 0 except dqt_hazir_o=1 once reset deasserts.
//   Loader in BOSTA; sequencer at Y with Y count 0. Bank contents not reset.
//  dqt_hazir_o = !dekod_aktif_i. A byte is accepted when gecerli && hazir.
//   Tables never change during decoding.
//  Loader FSM:
//   BOSTA: accepted byte is Pq/Tq (hi/lo nibble).
//    Pq==0 and Tq<=3: latch Tq, clear counter k, clear tablo_gecerli[Tq] -> YUKLE.
//    Otherwise: set dq_hata -> ATLA.
//   YUKLE: byte k is written to bank[Tq][zz2nat(k)]; write lands the next edge.
//    At k==63: set tablo_gecerli[Tq] the next cycle, then go to BOSTA.
//    A segment may hold several tables back to back.
//    segment_son on a byte with k<63: set dq_hata, bank stays invalid -> BOSTA.
//   ATLA: discard bytes until segment_son -> BOSTA.
//   segment_son on a BOSTA byte (extra byte after a full table): set dq_hata.
//  dq_hata_o clears only on reset or when a new segment's first byte is accepted in BOSTA.
//  Sequencer: an end of block is blk_gecerli_i && blk_hazir_i && blk_son_i on a clock edge.
//   1 component: stay on Y.
//   3 components: Y (mcu_y_blok_i times) -> Cb -> Cr -> Y, wrapping the Y count to 0.
//   Update lands the edge after the handshake, so the next block's first coefficient sees the new table.
//   yeni_cerceve_i forces Y, count 0, and wins over a simultaneous end of block.
//   mcu_y_blok_i==0 is treated as 1.
//  aktif_tablo_o = bilesen_tablo_i field for aktif_bilesen_o (combinational).
//  dq_katsayi_o = bank[aktif_tablo][dq_index_i], combinational and 0-latency.
//   If tablo_gecerli[aktif_tablo]==0, output 8'd1 (pass-through).
//  Asynchronous reset mid-load abandons the table: bank invalid, FSM to BOSTA.
// STRUCTURE
//  sabitler.vh: `DQ_TABLO_BIT, `BLOCK_AREA, `BLOCK_AREA_BIT, `HIGH/`LOW.
//   Also owns the FSM state codes BOSTA/YUKLE/ATLA and the component codes Y/CB/CR.
//  Sub-module zigzag_sira_rom: 6-bit zigzag index -> 6-bit natural index, combinational.
//  Banks: 4x64x8 register file, single write port, single read port.
// TESTING
//  1. Load Tq=0 with bytes 1..64 in zigzag order.
//     -> tablo_gecerli=0001; dq_index 0->1, 1->2, 8->3, 63->64.
//  2. Segment {0x01, 64 bytes of 16, 0x02, 64 bytes of 99}.
//     -> banks 1 and 2 valid, dq_hata=0, single segment_son accepted.
//  3. First byte 0x10 (Pq=1).
//     -> dq_hata=1, remaining bytes dropped, tablo_gecerli unchanged; next good segment clears the error.
//  4. segment_son on byte 30 of a table.
//     -> dq_hata=1, that bank invalid, lookup returns 8'd1.
//  5. 3 components, mcu_y_blok=2, tables Y=0 Cb=1 Cr=1; 8 end-of-block handshakes.
//     -> aktif_bilesen 0,0,1,2,0,0,1,2 per block.
//     Stall blk_hazir low with blk_son high -> no advance.
//  6. dekod_aktif_i=1 during a load.
//     -> dqt_hazir_o=0, no bank write; yeni_cerceve together with end of block -> Y, count 0.

Source files
------------

// File: rtl/dq_tablo_yonetici_pkg.sv
// Shared constants and type codes for the
// JPEG quantization table manager.
package dq_tablo_yonetici_pkg;

  localparam int TABLO_SAYISI   = 4;
  localparam int DQ_TABLO_BIT   = 8;
  localparam int BLOCK_AREA     = 64;
  localparam int BLOCK_AREA_BIT = 6;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    YUKLE = 2'd1,
    ATLA  = 2'd2
  } durum_t;

  typedef enum logic [1:0] {
    Y  = 2'd0,
    CB = 2'd1,
    CR = 2'd2
  } bilesen_t;

endpackage

// File: rtl/dq_tablo_yonetici_zigzag_sira_rom.sv
// Zigzag scan position to natural
// (row*8+col) coefficient index.
module zigzag_sira_rom
  import dq_tablo_yonetici_pkg::*;
(
  input  logic [BLOCK_AREA_BIT-1:0] zz_i,
  output logic [BLOCK_AREA_BIT-1:0] nat_o
);

  localparam logic [5:0] NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  assign nat_o = NAT[zz_i];

endmodule

// File: rtl/dq_tablo_yonetici.sv
// DQT loader, 4 table banks and MCU component
// sequencer feeding the dequantizer lookup.
module dq_tablo_yonetici
  import dq_tablo_yonetici_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] dqt_veri_i,
  input  logic       dqt_gecerli_i,
  input  logic       dqt_segment_son_i,
  output logic       dqt_hazir_o,
  input  logic       dekod_aktif_i,
  input  logic       yeni_cerceve_i,
  input  logic [1:0] bilesen_sayisi_i,
  input  logic [2:0] mcu_y_blok_i,
  input  logic [5:0] bilesen_tablo_i,
  input  logic       blk_gecerli_i,
  input  logic       blk_hazir_i,
  input  logic       blk_son_i,
  input  logic [5:0] dq_index_i,
  output logic [7:0] dq_katsayi_o,
  output logic [1:0] aktif_bilesen_o,
  output logic [1:0] aktif_tablo_o,
  output logic [3:0] tablo_gecerli_o,
  output logic       dq_hata_o
);

  durum_t     durum_q, durum_d;
  logic [1:0] tq_q, tq_d;
  logic [5:0] k_q, k_d;
  logic [3:0] gecerli_q, gecerli_d;
  logic       hata_q, hata_d;
  logic       seg_ici_q, seg_ici_d;
  logic       kabul, yaz;
  logic [5:0] nat;

  logic [DQ_TABLO_BIT-1:0] bank_q [TABLO_SAYISI][BLOCK_AREA];

  bilesen_t   bilesen_q, bilesen_d;
  logic [2:0] ysay_q, ysay_d;
  logic [2:0] ymax;
  logic       blk_bitti;
  logic [1:0] tablo;

  assign dqt_hazir_o = rstn_i & ~dekod_aktif_i;
  assign kabul       = dqt_gecerli_i & dqt_hazir_o;

  zigzag_sira_rom u_zz (
    .zz_i  (k_q),
    .nat_o (nat)
  );

  always_comb begin
    durum_d   = durum_q;
    tq_d      = tq_q;
    k_d       = k_q;
    gecerli_d = gecerli_q;
    hata_d    = hata_q;
    seg_ici_d = seg_ici_q;
    yaz       = LOW;
    if (kabul) begin
      seg_ici_d = ~dqt_segment_son_i;
      unique case (durum_q)
        BOSTA: begin
          // first byte of a fresh segment drops the old error
          if (!seg_ici_q) hata_d = LOW;
          if (dqt_segment_son_i) begin
            hata_d = HIGH;
          end else if (dqt_veri_i[7:4] != 4'd0 ||
                       dqt_veri_i[3:2] != 2'd0) begin
            hata_d  = HIGH;
            durum_d = ATLA;
          end else begin
            tq_d                       = dqt_veri_i[1:0];
            k_d                        = '0;
            gecerli_d[dqt_veri_i[1:0]] = LOW;
            durum_d                    = YUKLE;
          end
        end
        YUKLE: begin
          yaz = HIGH;
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) begin
            gecerli_d[tq_q] = HIGH;
            durum_d         = BOSTA;
          end else if (dqt_segment_son_i) begin
            hata_d  = HIGH;
            durum_d = BOSTA;
          end
        end
        ATLA: begin
          if (dqt_segment_son_i) durum_d = BOSTA;
        end
        default: durum_d = BOSTA;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= BOSTA;
      tq_q      <= '0;
      k_q       <= '0;
      gecerli_q <= '0;
      hata_q    <= LOW;
      seg_ici_q <= LOW;
    end else begin
      durum_q   <= durum_d;
      tq_q      <= tq_d;
      k_q       <= k_d;
      gecerli_q <= gecerli_d;
      hata_q    <= hata_d;
      seg_ici_q <= seg_ici_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz) bank_q[tq_q][nat] <= dqt_veri_i;
  end

  assign blk_bitti = blk_gecerli_i & blk_hazir_i & blk_son_i;
  assign ymax      = (mcu_y_blok_i == 3'd0) ? 3'd1 : mcu_y_blok_i;

  always_comb begin
    bilesen_d = bilesen_q;
    ysay_d    = ysay_q;
    if (yeni_cerceve_i) begin
      bilesen_d = Y;
      ysay_d    = '0;
    end else if (blk_bitti) begin
      if (bilesen_sayisi_i == 2'd3) begin
        unique case (bilesen_q)
          Y: begin
            if (ysay_q + 3'd1 >= ymax) begin
              bilesen_d = CB;
              ysay_d    = '0;
            end else begin
              ysay_d = ysay_q + 3'd1;
            end
          end
          CB: bilesen_d = CR;
          CR: begin
            bilesen_d = Y;
            ysay_d    = '0;
          end
          default: begin
            bilesen_d = Y;
            ysay_d    = '0;
          end
        endcase
      end else begin
        bilesen_d = Y;
        ysay_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bilesen_q <= Y;
      ysay_q    <= '0;
    end else begin
      bilesen_q <= bilesen_d;
      ysay_q    <= ysay_d;
    end
  end

  always_comb begin
    tablo = 2'd0;
    unique case (bilesen_q)
      Y:       tablo = bilesen_tablo_i[1:0];
      CB:      tablo = bilesen_tablo_i[3:2];
      CR:      tablo = bilesen_tablo_i[5:4];
      default: tablo = 2'd0;
    endcase
  end

  assign aktif_bilesen_o = bilesen_q;
  assign aktif_tablo_o   = tablo;
  assign tablo_gecerli_o = gecerli_q;
  assign dq_hata_o       = hata_q;
  assign dq_katsayi_o    = gecerli_q[tablo] ?
                           bank_q[tablo][dq_index_i] : 8'd1;

endmodule

// File: tb/tb_dq_tablo_yonetici.sv
// Bench for dq_tablo_yonetici: random tables and
// block streams against a spec-level model.
module tb_dq_tablo_yonetici;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] dqt_veri_i;
  logic       dqt_gecerli_i;
  logic       dqt_segment_son_i;
  logic       dqt_hazir_o;
  logic       dekod_aktif_i;
  logic       yeni_cerceve_i;
  logic [1:0] bilesen_sayisi_i;
  logic [2:0] mcu_y_blok_i;
  logic [5:0] bilesen_tablo_i;
  logic       blk_gecerli_i;
  logic       blk_hazir_i;
  logic       blk_son_i;
  logic [5:0] dq_index_i;
  logic [7:0] dq_katsayi_o;
  logic [1:0] aktif_bilesen_o;
  logic [1:0] aktif_tablo_o;
  logic [3:0] tablo_gecerli_o;
  logic       dq_hata_o;

  always #5 clk_i = ~clk_i;

  dq_tablo_yonetici dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .dqt_veri_i        (dqt_veri_i),
    .dqt_gecerli_i     (dqt_gecerli_i),
    .dqt_segment_son_i (dqt_segment_son_i),
    .dqt_hazir_o       (dqt_hazir_o),
    .dekod_aktif_i     (dekod_aktif_i),
    .yeni_cerceve_i    (yeni_cerceve_i),
    .bilesen_sayisi_i  (bilesen_sayisi_i),
    .mcu_y_blok_i      (mcu_y_blok_i),
    .bilesen_tablo_i   (bilesen_tablo_i),
    .blk_gecerli_i     (blk_gecerli_i),
    .blk_hazir_i       (blk_hazir_i),
    .blk_son_i         (blk_son_i),
    .dq_index_i        (dq_index_i),
    .dq_katsayi_o      (dq_katsayi_o),
    .aktif_bilesen_o   (aktif_bilesen_o),
    .aktif_tablo_o     (aktif_tablo_o),
    .tablo_gecerli_o   (tablo_gecerli_o),
    .dq_hata_o         (dq_hata_o)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         zz [64];
  logic [7:0] tv [64];
  logic [7:0] mbank [4][64];
  logic [3:0] mvalid;
  logic       merr;

  // zigzag order built by walking anti-diagonals
  function automatic void build_zz();
    int i;
    i = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz[i] = r * 8 + (s - r);
          i++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz[i] = r * 8 + (s - r);
          i++;
        end
      end
    end
  endfunction

  function automatic logic [7:0] mexp(input int tq, input int ix);
    return mvalid[tq] ? mbank[tq][ix] : 8'd1;
  endfunction

  task automatic model_table(input int tq);
    for (int k = 0; k < 64; k++) mbank[tq][zz[k]] = tv[k];
    mvalid[tq] = 1'b1;
  endtask

  task automatic rand_tv();
    for (int k = 0; k < 64; k++) tv[k] = 8'($urandom_range(1, 255));
  endtask

  task automatic send(input logic [7:0] b, input logic son);
    dqt_veri_i        = b;
    dqt_gecerli_i     = 1'b1;
    dqt_segment_son_i = son;
    @(posedge clk_i);
    #1;
    dqt_gecerli_i     = 1'b0;
    dqt_segment_son_i = 1'b0;
  endtask

  task automatic send_table(input int tq, input int n, input logic son);
    send(8'(tq), 1'b0);
    for (int k = 0; k < n; k++) send(tv[k], son && (k == n - 1));
  endtask

  task automatic eob();
    blk_gecerli_i = 1'b1;
    blk_hazir_i   = 1'b1;
    blk_son_i     = 1'b1;
    @(posedge clk_i);
    #1;
    blk_gecerli_i = 1'b0;
    blk_hazir_i   = 1'b0;
    blk_son_i     = 1'b0;
  endtask

  task automatic frame_start();
    yeni_cerceve_i = 1'b1;
    @(posedge clk_i);
    #1;
    yeni_cerceve_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    #1;
    n_cmp++;
    if (dqt_hazir_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_hazir: got %b want 1", dqt_hazir_o);
    end
    n_cmp++;
    if (tablo_gecerli_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_gecerli: got %b want 0000", tablo_gecerli_o);
    end
    n_cmp++;
    if (dq_hata_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_hata: got %b want 0", dq_hata_o);
    end
    n_cmp++;
    if (aktif_bilesen_o !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_bilesen: got %0d want 0", aktif_bilesen_o);
    end
    n_cmp++;
    if (aktif_tablo_o !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_tablo: got %0d want 0", aktif_tablo_o);
    end
  endtask

  task automatic test_load_single();
    int fix [4];
    int fexp [4];
    fix  = '{0, 1, 8, 63};
    fexp = '{1, 2, 3, 64};
    for (int k = 0; k < 64; k++) tv[k] = 8'(k + 1);
    bilesen_tablo_i = 6'd0;
    send_table(0, 64, 1'b1);
    model_table(0);
    n_cmp++;
    if (tablo_gecerli_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL t1_gecerli: got %b want 0001", tablo_gecerli_o);
    end
    n_cmp++;
    if (dq_hata_o !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_hata: got %b want 0", dq_hata_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      dq_index_i = 6'(fix[i]);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== 8'(fexp[i])) begin
        n_bad++;
        $display("FAIL t1_lookup[%0d]: got %0d want %0d",
                 fix[i], dq_katsayi_o, fexp[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      int ix;
      ix = $urandom_range(0, 63);
      @(negedge clk_i);
      dq_index_i = 6'(ix);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== mexp(0, ix)) begin
        n_bad++;
        $display("FAIL t1_rand[%0d]: got %0d want %0d",
                 ix, dq_katsayi_o, mexp(0, ix));
      end
    end
  endtask

  task automatic test_multi_table();
    rand_tv();
    send_table(1, 64, 1'b0);
    model_table(1);
    rand_tv();
    send_table(2, 64, 1'b1);
    model_table(2);
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL t2_gecerli: got %b want %b", tablo_gecerli_o, mvalid);
    end
    n_cmp++;
    if (dq_hata_o !== 1'b0) begin
      n_bad++;
      $display("FAIL t2_hata: got %b want 0", dq_hata_o);
    end
    for (int i = 0; i < 24; i++) begin
      int ix;
      int tq;
      ix = $urandom_range(0, 63);
      tq = 1 + (i % 2);
      @(negedge clk_i);
      bilesen_tablo_i = 6'(tq);
      dq_index_i      = 6'(ix);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== mexp(tq, ix)) begin
        n_bad++;
        $display("FAIL t2_lookup b%0d[%0d]: got %0d want %0d",
                 tq, ix, dq_katsayi_o, mexp(tq, ix));
      end
    end
  endtask

  task automatic test_bad_pq();
    send(8'h10, 1'b0);
    for (int i = 0; i < 10; i++) send(8'($urandom), i == 9);
    merr = 1'b1;
    n_cmp++;
    if (dq_hata_o !== merr) begin
      n_bad++;
      $display("FAIL t3_hata: got %b want %b", dq_hata_o, merr);
    end
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL t3_gecerli: got %b want %b", tablo_gecerli_o, mvalid);
    end
    rand_tv();
    send_table(3, 64, 1'b1);
    model_table(3);
    merr = 1'b0;
    n_cmp++;
    if (dq_hata_o !== merr) begin
      n_bad++;
      $display("FAIL t3_clear: got %b want %b", dq_hata_o, merr);
    end
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL t3_gecerli2: got %b want %b", tablo_gecerli_o, mvalid);
    end
    for (int i = 0; i < 8; i++) begin
      int ix;
      ix = $urandom_range(0, 63);
      @(negedge clk_i);
      bilesen_tablo_i = 6'd3;
      dq_index_i      = 6'(ix);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== mexp(3, ix)) begin
        n_bad++;
        $display("FAIL t3_lookup[%0d]: got %0d want %0d",
                 ix, dq_katsayi_o, mexp(3, ix));
      end
    end
  endtask

  task automatic test_truncated();
    rand_tv();
    send_table(1, 30, 1'b1);
    mvalid[1] = 1'b0;
    merr      = 1'b1;
    n_cmp++;
    if (dq_hata_o !== merr) begin
      n_bad++;
      $display("FAIL t4_hata: got %b want %b", dq_hata_o, merr);
    end
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL t4_gecerli: got %b want %b", tablo_gecerli_o, mvalid);
    end
    for (int i = 0; i < 6; i++) begin
      int ix;
      ix = $urandom_range(0, 63);
      @(negedge clk_i);
      bilesen_tablo_i = 6'd1;
      dq_index_i      = 6'(ix);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== mexp(1, ix)) begin
        n_bad++;
        $display("FAIL t4_lookup[%0d]: got %0d want %0d",
                 ix, dq_katsayi_o, mexp(1, ix));
      end
    end
  endtask

  task automatic test_extra_byte();
    // fresh segment: clears the error, then one byte too many
    rand_tv();
    send_table(2, 64, 1'b0);
    model_table(2);
    send(8'h00, 1'b1);
    merr = 1'b1;
    n_cmp++;
    if (dq_hata_o !== merr) begin
      n_bad++;
      $display("FAIL t_extra_hata: got %b want %b", dq_hata_o, merr);
    end
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL t_extra_gecerli: got %b want %b",
               tablo_gecerli_o, mvalid);
    end
  endtask

  task automatic test_sequencer();
    for (int trial = 0; trial < 5; trial++) begin
      int ny;
      int eff;
      int ncomp;
      logic [5:0] tabs;
      ny    = (trial == 0) ? 2 : (trial == 1) ? 0 : $urandom_range(1, 4);
      tabs  = (trial == 0) ? 6'b01_01_00 : 6'($urandom);
      ncomp = (trial == 4) ? 1 : 3;
      eff   = (ny == 0) ? 1 : ny;
      bilesen_sayisi_i = 2'(ncomp);
      mcu_y_blok_i     = 3'(ny);
      bilesen_tablo_i  = tabs;
      frame_start();
      for (int n = 0; n < 2 * (eff + 2); n++) begin
        int pos;
        int ec;
        int et;
        int r;
        pos = n % (eff + 2);
        ec  = (ncomp == 1) ? 0 : (pos < eff) ? 0 : pos - eff + 1;
        et  = (tabs >> (2 * ec)) & 3;
        n_cmp++;
        if (aktif_bilesen_o !== 2'(ec)) begin
          n_bad++;
          $display("FAIL seq_bilesen tr%0d blk%0d: got %0d want %0d",
                   trial, n, aktif_bilesen_o, ec);
        end
        n_cmp++;
        if (aktif_tablo_o !== 2'(et)) begin
          n_bad++;
          $display("FAIL seq_tablo tr%0d blk%0d: got %0d want %0d",
                   trial, n, aktif_tablo_o, et);
        end
        r = $urandom_range(0, 2);
        blk_gecerli_i = 1'b1;
        blk_son_i     = 1'b1;
        blk_hazir_i   = 1'b0;
        repeat (r) @(posedge clk_i);
        blk_son_i   = 1'b0;
        blk_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        blk_gecerli_i = 1'b0;
        blk_hazir_i   = 1'b0;
        n_cmp++;
        if (aktif_bilesen_o !== 2'(ec)) begin
          n_bad++;
          $display("FAIL seq_stall tr%0d blk%0d: got %0d want %0d",
                   trial, n, aktif_bilesen_o, ec);
        end
        eob();
      end
    end
  endtask

  task automatic test_dekod_aktif();
    dekod_aktif_i = 1'b1;
    #1;
    n_cmp++;
    if (dqt_hazir_o !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_hazir: got %b want 0", dqt_hazir_o);
    end
    rand_tv();
    send_table(1, 64, 1'b1);
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL t6_gecerli: got %b want %b", tablo_gecerli_o, mvalid);
    end
    n_cmp++;
    if (dq_hata_o !== merr) begin
      n_bad++;
      $display("FAIL t6_hata: got %b want %b", dq_hata_o, merr);
    end
    bilesen_sayisi_i = 2'd3;
    mcu_y_blok_i     = 3'd2;
    bilesen_tablo_i  = 6'b10_01_00;
    frame_start();
    for (int i = 0; i < 6; i++) begin
      int ix;
      ix = $urandom_range(0, 63);
      @(negedge clk_i);
      dq_index_i = 6'(ix);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== mexp(0, ix)) begin
        n_bad++;
        $display("FAIL t6_lookup[%0d]: got %0d want %0d",
                 ix, dq_katsayi_o, mexp(0, ix));
      end
    end
    eob();
    yeni_cerceve_i = 1'b1;
    eob();
    yeni_cerceve_i = 1'b0;
    n_cmp++;
    if (aktif_bilesen_o !== 2'd0) begin
      n_bad++;
      $display("FAIL t6_yeni: got %0d want 0", aktif_bilesen_o);
    end
    eob();
    n_cmp++;
    if (aktif_bilesen_o !== 2'd0) begin
      n_bad++;
      $display("FAIL t6_sayac0: got %0d want 0", aktif_bilesen_o);
    end
    eob();
    n_cmp++;
    if (aktif_bilesen_o !== 2'd1) begin
      n_bad++;
      $display("FAIL t6_cb: got %0d want 1", aktif_bilesen_o);
    end
    dekod_aktif_i = 1'b0;
  endtask

  task automatic test_async_reset();
    rand_tv();
    send(8'h00, 1'b0);
    for (int k = 0; k < 10; k++) send(tv[k], 1'b0);
    #2;
    rstn_i = 1'b0;
    #1;
    mvalid = 4'b0000;
    merr   = 1'b0;
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL ar_gecerli: got %b want %b", tablo_gecerli_o, mvalid);
    end
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    rand_tv();
    send_table(2, 64, 1'b1);
    model_table(2);
    n_cmp++;
    if (tablo_gecerli_o !== mvalid) begin
      n_bad++;
      $display("FAIL ar_reload: got %b want %b", tablo_gecerli_o, mvalid);
    end
    n_cmp++;
    if (dq_hata_o !== merr) begin
      n_bad++;
      $display("FAIL ar_hata: got %b want %b", dq_hata_o, merr);
    end
    frame_start();
    for (int i = 0; i < 6; i++) begin
      int ix;
      int tq;
      ix = $urandom_range(0, 63);
      tq = (i % 2 == 0) ? 2 : 0;
      @(negedge clk_i);
      bilesen_tablo_i = 6'(tq);
      dq_index_i      = 6'(ix);
      #1;
      n_cmp++;
      if (dq_katsayi_o !== mexp(tq, ix)) begin
        n_bad++;
        $display("FAIL ar_lookup b%0d[%0d]: got %0d want %0d",
                 tq, ix, dq_katsayi_o, mexp(tq, ix));
      end
    end
  endtask

  initial begin
    build_zz();
    mvalid            = 4'b0000;
    merr              = 1'b0;
    rstn_i            = 1'b0;
    dqt_veri_i        = 8'd0;
    dqt_gecerli_i     = 1'b0;
    dqt_segment_son_i = 1'b0;
    dekod_aktif_i     = 1'b0;
    yeni_cerceve_i    = 1'b0;
    bilesen_sayisi_i  = 2'd1;
    mcu_y_blok_i      = 3'd1;
    bilesen_tablo_i   = 6'd0;
    blk_gecerli_i     = 1'b0;
    blk_hazir_i       = 1'b0;
    blk_son_i         = 1'b0;
    dq_index_i        = 6'd0;
    test_reset();
    test_load_single();
    test_multi_table();
    test_bad_pq();
    test_truncated();
    test_extra_byte();
    test_sequencer();
    test_dekod_aktif();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
